// File: rtl/br_dump_if.sv
// Bundle between the register-bank dump engine, its bank read port and the
// word consumer. The engine uses "master", the surrounding environment uses "slave".
interface br_dump_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              start;
   logic [ADDR_W-1:0] first_idx;
   logic [ADDR_W-1:0] last_idx;
   logic [ADDR_W-1:0] rf_addr;
   logic [DATA_W-1:0] rf_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_index;
   logic              busy;
   logic              done;

   modport master (
      input  start, first_idx, last_idx, rf_data, out_ready,
      output rf_addr, out_valid, out_data, out_index, busy, done
   );

   modport slave (
      output start, first_idx, last_idx, rf_data, out_ready,
      input  rf_addr, out_valid, out_data, out_index, busy, done
   );
endinterface

// File: rtl/br_dump.sv
// Debug read-out engine: walks a captured index range of the register bank
// through a read-only port and streams each word over a valid/ready handshake.
module br_dump #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NREG   = 32
) (
   input  logic      clk,
   input  logic      rst,
   br_dump_if.master bus
);

   localparam logic [ADDR_W-1:0] MAX_IDX = ADDR_W'(NREG - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      OUT  = 2'd2,
      FIN  = 2'd3
   } state_t;

   state_t            state_r,     state_s;
   logic [ADDR_W-1:0] cur_r,       cur_s;
   logic [ADDR_W-1:0] last_r,      last_s;
   logic [DATA_W-1:0] out_data_r,  out_data_s;
   logic [ADDR_W-1:0] out_index_r, out_index_s;
   logic              out_valid_r, out_valid_s;
   logic              busy_r,      busy_s;
   logic              done_r,      done_s;

   function automatic logic range_nonempty(input logic [ADDR_W-1:0] first,
                                           input logic [ADDR_W-1:0] last);
      return (first <= last);
   endfunction

   // The MAX_IDX term is a guard against ever wrapping past the top register.
   function automatic logic at_end(input logic [ADDR_W-1:0] cur,
                                   input logic [ADDR_W-1:0] last);
      return (cur == last) || (cur == MAX_IDX);
   endfunction

   // Next-state and next-output computation for the dump sequencer.
   always_comb begin
      state_s     = state_r;
      cur_s       = cur_r;
      last_s      = last_r;
      out_data_s  = out_data_r;
      out_index_s = out_index_r;
      out_valid_s = out_valid_r;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               if (range_nonempty(bus.first_idx, bus.last_idx)) begin
                  cur_s   = bus.first_idx;
                  last_s  = bus.last_idx;
                  state_s = READ;
               end else begin
                  state_s = FIN;
               end
            end else begin
               state_s = IDLE;
            end
         end
         READ: begin
            // Snapshot taken here; later bank writes never touch the held word.
            out_data_s  = bus.rf_data;
            out_index_s = cur_r;
            out_valid_s = 1'b1;
            state_s     = OUT;
         end
         OUT: begin
            if (bus.out_ready) begin
               out_valid_s = 1'b0;
               if (at_end(cur_r, last_r)) begin
                  state_s = FIN;
               end else begin
                  cur_s   = cur_r + ADDR_W'(1);
                  state_s = READ;
               end
            end else begin
               state_s = OUT;
            end
         end
         FIN: begin
            state_s = IDLE;
         end
         default: begin
            out_valid_s = 1'b0;
            state_s     = IDLE;
         end
      endcase
      busy_s = (state_s != IDLE);
      done_s = (state_s == FIN);
   end

   // State, datapath and registered status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         cur_r       <= {ADDR_W{1'b0}};
         last_r      <= {ADDR_W{1'b0}};
         out_data_r  <= {DATA_W{1'b0}};
         out_index_r <= {ADDR_W{1'b0}};
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         cur_r       <= cur_s;
         last_r      <= last_s;
         out_data_r  <= out_data_s;
         out_index_r <= out_index_s;
         out_valid_r <= out_valid_s;
         busy_r      <= busy_s;
         done_r      <= done_s;
      end
   end

   assign bus.rf_addr   = cur_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;
   assign bus.out_index = out_index_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;

endmodule

// File: tb/tb_br_dump.sv
// Self-checking bench for br_dump: queue-based reference model compared every
// cycle, randomized dumps with bank writes and backpressure, plus directed cases.
module tb_br_dump;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   br_dump_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   br_dump #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [DATA_W-1:0] bank [32];
   assign bus.rf_data = bank[bus.rf_addr];

   int vectors     = 0;
   int miscompares = 0;
   int done_seen   = 0;

   // Reference model: indices still to emit, the word on offer, a pending fetch.
   logic [4:0]  q[$];
   bit          m_have = 1'b0;
   bit          m_gap  = 1'b0;
   bit          m_done = 1'b0;
   logic [4:0]  m_idx  = 5'd0;
   logic [31:0] m_data = 32'd0;

   logic [4:0]  acc_idx[$];
   logic [31:0] acc_data[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int idx, input logic [31:0] d);
      if (idx != 0) bank[idx] = d;
   endtask

   task automatic start_dump(input int f, input int l);
      bus.first_idx = 5'(f);
      bus.last_idx  = 5'(l);
      bus.start     = 1'b1;
      tick();
      bus.start     = 1'b0;
   endtask

   function automatic bit model_busy();
      return m_have || m_gap || m_done;
   endfunction

   // Run until idle; optionally randomize ready, bank writes and ignored starts.
   task automatic run_idle(input bit rnd, input int budget);
      int n = 0;
      while ((bus.busy || model_busy()) && n < budget) begin
         if (rnd) begin
            bus.out_ready = (($urandom % 4) != 0);
            if (($urandom % 3) == 0) wr($urandom_range(1, 31), $urandom);
            bus.first_idx = 5'($urandom);
            bus.last_idx  = 5'($urandom);
            bus.start     = m_have && (($urandom % 6) == 0);
         end
         tick();
         bus.start = 1'b0;
         n++;
      end
      if (n >= budget) begin
         vectors++;
         miscompares++;
         $display("FAIL timeout: still busy after %0d cycles, required idle", n);
      end
   endtask

   // Model advances on each clock edge from the inputs the DUT also saw.
   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            q.delete();
            m_have = 1'b0;
            m_gap  = 1'b0;
            m_done = 1'b0;
         end else begin
            bit fin;
            fin = 1'b0;
            if (m_have) begin
               if (bus.out_ready) begin
                  m_have = 1'b0;
                  if (q.size() == 0) fin = 1'b1;
                  else m_gap = 1'b1;
               end
            end else if (m_gap) begin
               m_idx  = q.pop_front();
               m_data = bank[m_idx];
               m_have = 1'b1;
               m_gap  = 1'b0;
            end else if (!m_done && bus.start) begin
               if (bus.first_idx <= bus.last_idx) begin
                  for (int i = int'(bus.first_idx); i <= int'(bus.last_idx); i++)
                     q.push_back(5'(i));
                  m_gap = 1'b1;
               end else begin
                  fin = 1'b1;
               end
            end
            m_done = fin;
         end
      end
   end

   // Compare DUT outputs with the model mid-cycle and log accepted words.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            check("out_valid", 32'(bus.out_valid), 32'(m_have));
            check("busy", 32'(bus.busy), 32'(model_busy()));
            check("done", 32'(bus.done), 32'(m_done));
            if (m_have) begin
               check("out_index", 32'(bus.out_index), 32'(m_idx));
               check("out_data", bus.out_data, m_data);
            end
            if (m_gap && q.size() > 0) check("rf_addr", 32'(bus.rf_addr), 32'(q[0]));
            if (bus.out_valid && bus.out_ready) begin
               acc_idx.push_back(bus.out_index);
               acc_data.push_back(bus.out_data);
            end
            if (bus.done) done_seen++;
         end
      end
   end

   initial begin
      logic [31:0] exp2 [6];
      int done_before;
      exp2[0] = 32'h0000_0000; exp2[1] = 32'h1111_1111; exp2[2] = 32'h0000_0000;
      exp2[3] = 32'h0000_0000; exp2[4] = 32'h0000_0000; exp2[5] = 32'hDEAD_BEEF;
      for (int i = 0; i < 32; i++) bank[i] = 32'd0;
      bus.start     = 1'b0;
      bus.first_idx = 5'd0;
      bus.last_idx  = 5'd0;
      bus.out_ready = 1'b1;

      // Reset values
      tick();
      tick();
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_data", bus.out_data, 32'd0);
      check("rst_index", 32'(bus.out_index), 32'd0);
      check("rst_rf_addr", 32'(bus.rf_addr), 32'd0);
      rst = 1'b0;
      tick();

      // Basic dump 0..5 with literal expectations and first-word latency
      wr(1, 32'h1111_1111);
      wr(5, 32'hDEAD_BEEF);
      acc_idx.delete(); acc_data.delete();
      start_dump(0, 5);
      check("lat_read_valid", 32'(bus.out_valid), 32'd0);
      check("lat_read_busy", 32'(bus.busy), 32'd1);
      tick();
      check("lat_first_valid", 32'(bus.out_valid), 32'd1);
      check("lat_first_index", 32'(bus.out_index), 32'd0);
      done_before = done_seen;
      run_idle(1'b0, 100);
      check("d05_count", 32'(acc_idx.size()), 32'd6);
      for (int i = 0; i < 6 && i < acc_idx.size(); i++) begin
         check("d05_index", 32'(acc_idx[i]), 32'(i));
         check("d05_data", acc_data[i], exp2[i]);
      end
      check("d05_done_once", 32'(done_seen - done_before), 32'd1);
      check("d05_busy_after", 32'(bus.busy), 32'd0);

      // Backpressure plus snapshot of x5
      bus.out_ready = 1'b0;
      start_dump(5, 5);
      tick();
      for (int i = 0; i < 10; i++) begin
         if (i == 3) wr(5, 32'hCAFE_F00D);
         check("bp_valid", 32'(bus.out_valid), 32'd1);
         check("bp_data", bus.out_data, 32'hDEAD_BEEF);
         if (i < 9) tick();
      end
      bus.out_ready = 1'b1;
      tick();
      check("bp_valid_drop", 32'(bus.out_valid), 32'd0);
      check("bp_done", 32'(bus.done), 32'd1);
      tick();
      check("bp_done_end", 32'(bus.done), 32'd0);
      acc_idx.delete(); acc_data.delete();
      start_dump(5, 5);
      run_idle(1'b0, 50);
      check("snap_count", 32'(acc_idx.size()), 32'd1);
      if (acc_data.size() > 0) check("snap_new", acc_data[0], 32'hCAFE_F00D);

      // Empty range
      acc_idx.delete();
      start_dump(7, 3);
      check("empty_done", 32'(bus.done), 32'd1);
      check("empty_busy", 32'(bus.busy), 32'd1);
      check("empty_valid", 32'(bus.out_valid), 32'd0);
      tick();
      check("empty_idle", 32'(bus.busy), 32'd0);
      check("empty_words", 32'(acc_idx.size()), 32'd0);

      // Single top register, then full range under random traffic
      start_dump(31, 31);
      run_idle(1'b0, 50);
      check("top_count", 32'(acc_idx.size()), 32'd1);
      if (acc_idx.size() > 0) check("top_index", 32'(acc_idx[0]), 32'd31);
      acc_idx.delete();
      start_dump(0, 31);
      run_idle(1'b1, 600);
      check("full_count", 32'(acc_idx.size()), 32'd32);
      if (acc_idx.size() > 0) check("full_last", 32'(acc_idx[acc_idx.size()-1]), 32'd31);
      tick();
      check("full_no_wrap", 32'(bus.busy), 32'd0);

      // Restart request mid-dump is ignored
      bus.out_ready = 1'b1;
      acc_idx.delete();
      start_dump(10, 20);
      tick(); tick(); tick();
      bus.first_idx = 5'd0; bus.last_idx = 5'd2; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      run_idle(1'b0, 100);
      check("restart_count", 32'(acc_idx.size()), 32'd11);
      if (acc_idx.size() > 0) check("restart_first", 32'(acc_idx[0]), 32'd10);

      // Asynchronous reset while a word is held
      bus.out_ready = 1'b0;
      start_dump(3, 9);
      tick();
      done_before = done_seen;
      #3 rst = 1'b1;
      #1;
      check("arst_valid", 32'(bus.out_valid), 32'd0);
      check("arst_busy", 32'(bus.busy), 32'd0);
      tick(); tick();
      rst = 1'b0;
      tick();
      check("arst_no_done", 32'(done_seen - done_before), 32'd0);
      bus.out_ready = 1'b1;
      acc_idx.delete();
      start_dump(3, 6);
      run_idle(1'b0, 100);
      check("arst_redump_count", 32'(acc_idx.size()), 32'd4);
      if (acc_idx.size() > 0) check("arst_redump_first", 32'(acc_idx[0]), 32'd3);

      // Randomized dumps
      for (int t = 0; t < 40; t++) begin
         int f, l;
         f = $urandom_range(0, 31);
         l = (($urandom % 8) == 0) ? $urandom_range(0, 31) : $urandom_range(f, 31);
         bus.out_ready = (($urandom % 2) != 0);
         start_dump(f, l);
         run_idle(1'b1, 600);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
